// File: rtl/kitchen_countdown.sv
// MM:SS BCD countdown for the kitchen timer: button set, tick-driven countdown,
// pause and a timed alarm.
//   state   | meaning
//   S_SET   | buttons edit the time, waiting for start
//   S_RUN   | counting down one second per tick
//   S_PAUSE | time frozen, start resumes, sec clears
//   S_ALARM | time at 00:00, alarm held for ALARM_TICKS ticks
module kitchen_countdown #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_min_n,
  input  logic       btn_sec_n,
  input  logic       btn_start_n,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_ALARM} state_t;

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS);

  state_t     state, state_nx;
  logic [2:0] sync_min, sync_sec, sync_start;
  logic       press_min, press_sec, press_start;
  logic [7:0] alarm_cnt, alarm_cnt_nx;
  logic [3:0] min_tens_nx, min_ones_nx, sec_tens_nx, sec_ones_nx;
  logic [3:0] inc_mt, inc_mo, inc_st, inc_so;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       time_zero, dec_zero;
  logic       running_nx, alarm_nx, done_nx;

  // bit 1 is the synchronized level, bit 2 its previous value
  assign press_min   = sync_min[2]   & ~sync_min[1];
  assign press_sec   = sync_sec[2]   & ~sync_sec[1];
  assign press_start = sync_start[2] & ~sync_start[1];

  assign time_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd0);

  always_comb begin
    inc_mt = min_tens;
    inc_mo = min_ones + 4'd1;
    if (min_ones >= 4'd9) begin
      inc_mo = 4'd0;
      inc_mt = (min_tens >= 4'd9) ? 4'd0 : min_tens + 4'd1;
    end
    inc_st = sec_tens;
    inc_so = sec_ones + 4'd1;
    if (sec_ones >= 4'd9) begin
      inc_so = 4'd0;
      inc_st = (sec_tens >= 4'd5) ? 4'd0 : sec_tens + 4'd1;
    end
  end

  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_so = 4'd9;
      dec_st = sec_tens - 4'd1;
      if (sec_tens == 4'd0) begin
        dec_st = 4'd5;
        dec_mo = min_ones - 4'd1;
        if (min_ones == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = (min_tens == 4'd0) ? 4'd0 : min_tens - 4'd1;
        end
      end
    end
    dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
               (dec_st == 4'd0) && (dec_so == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_SET;
      sync_min   <= 3'b111;
      sync_sec   <= 3'b111;
      sync_start <= 3'b111;
      alarm_cnt  <= 8'd0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      running    <= 1'b0;
      alarm      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      sync_min   <= {sync_min[1:0], btn_min_n};
      sync_sec   <= {sync_sec[1:0], btn_sec_n};
      sync_start <= {sync_start[1:0], btn_start_n};
      alarm_cnt  <= alarm_cnt_nx;
      min_tens   <= min_tens_nx;
      min_ones   <= min_ones_nx;
      sec_tens   <= sec_tens_nx;
      sec_ones   <= sec_ones_nx;
      running    <= running_nx;
      alarm      <= alarm_nx;
      done       <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    alarm_cnt_nx = alarm_cnt;
    min_tens_nx  = min_tens;
    min_ones_nx  = min_ones;
    sec_tens_nx  = sec_tens;
    sec_ones_nx  = sec_ones;
    case (state)
      S_SET: begin
        if (press_start && !time_zero) begin
          state_nx = S_RUN;
        end else begin
          if (press_min) begin
            min_tens_nx = inc_mt;
            min_ones_nx = inc_mo;
          end
          if (press_sec) begin
            sec_tens_nx = inc_st;
            sec_ones_nx = inc_so;
          end
        end
      end
      S_RUN: begin
        if (tick) begin
          min_tens_nx = dec_mt;
          min_ones_nx = dec_mo;
          sec_tens_nx = dec_st;
          sec_ones_nx = dec_so;
        end
        // decrement is applied before the start press is considered
        if (tick && dec_zero) begin
          state_nx     = S_ALARM;
          alarm_cnt_nx = 8'd0;
        end else if (press_start) begin
          state_nx = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (press_start) begin
          state_nx = S_RUN;
        end else if (press_sec) begin
          state_nx    = S_SET;
          min_tens_nx = 4'd0;
          min_ones_nx = 4'd0;
          sec_tens_nx = 4'd0;
          sec_ones_nx = 4'd0;
        end
      end
      S_ALARM: begin
        if (press_start) begin
          state_nx     = S_SET;
          alarm_cnt_nx = 8'd0;
        end else if (tick) begin
          alarm_cnt_nx = alarm_cnt + 8'd1;
          if (alarm_cnt + 8'd1 >= ALARM_LAST) begin
            state_nx     = S_SET;
            alarm_cnt_nx = 8'd0;
          end
        end
      end
      default: state_nx = S_SET;
    endcase
  end

  always_comb begin
    running_nx = (state_nx == S_RUN);
    alarm_nx   = (state_nx == S_ALARM);
    done_nx    = (state == S_RUN) && (state_nx == S_ALARM);
  end

endmodule

// File: tb/tb_kitchen_countdown.sv
// Bench for kitchen_countdown: directed vector table, hand sequences for the
// multi-cycle corners, and random stimulus against a seconds-based model.
module tb_kitchen_countdown;

  localparam int AT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       bmin = 1'b1;
  logic       bsec = 1'b1;
  logic       bstart = 1'b1;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, alarm, done;

  always #5 clk = ~clk;

  kitchen_countdown #(.ALARM_TICKS(AT)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_min_n(bmin), .btn_sec_n(bsec), .btn_start_n(bstart),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .alarm(alarm), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  // model: time as plain minutes/seconds, state 0 SET 1 RUN 2 PAUSE 3 ALARM
  int       m_min = 0, m_sec = 0, m_st = 0, m_acnt = 0;
  bit       m_done = 0;
  bit [2:0] h_min = '1, h_sec = '1, h_stb = '1;

  function automatic void model_step(input bit r, input bit t,
                                     input bit rm, input bit rs, input bit rb);
    bit pm, ps, pb;
    int total;
    if (!r) begin
      m_min = 0; m_sec = 0; m_st = 0; m_acnt = 0; m_done = 0;
      h_min = '1; h_sec = '1; h_stb = '1;
      return;
    end
    pm = h_min[2] && !h_min[1];
    ps = h_sec[2] && !h_sec[1];
    pb = h_stb[2] && !h_stb[1];
    m_done = 0;
    total = m_min * 60 + m_sec;
    case (m_st)
      0: begin
        if (pb && total != 0) m_st = 1;
        else begin
          if (pm) m_min = (m_min + 1) % 100;
          if (ps) m_sec = (m_sec + 1) % 60;
        end
      end
      1: begin
        if (t) total = total - 1;
        m_min = total / 60;
        m_sec = total % 60;
        if (total == 0) begin
          m_st = 3; m_done = 1; m_acnt = 0;
        end else if (pb) m_st = 2;
      end
      2: begin
        if (pb) m_st = 1;
        else if (ps) begin
          m_min = 0; m_sec = 0; m_st = 0;
        end
      end
      default: begin
        if (pb) begin
          m_st = 0; m_acnt = 0;
        end else if (t) begin
          m_acnt = m_acnt + 1;
          if (m_acnt == AT) begin
            m_st = 0; m_acnt = 0;
          end
        end
      end
    endcase
    h_min = {h_min[1:0], rm};
    h_sec = {h_sec[1:0], rs};
    h_stb = {h_stb[1:0], rb};
  endfunction

  function automatic logic [18:0] model_out();
    logic [3:0] a, b, c, d;
    a = 4'(m_min / 10); b = 4'(m_min % 10);
    c = 4'(m_sec / 10); d = 4'(m_sec % 10);
    return {a, b, c, d, (m_st == 1), (m_st == 3), m_done};
  endfunction

  task automatic cyc();
    logic [18:0] got, exp;
    @(posedge clk);
    model_step(rst_n, tick, bmin, bsec, bstart);
    @(negedge clk);
    cyc_no++;
    got = {min_tens, min_ones, sec_tens, sec_ones, running, alarm, done};
    exp = model_out();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model cycle %0d: got digits %h run/alm/done %b, expected digits %h run/alm/done %b",
               cyc_no, got[18:3], got[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic check_exp(input string name, input logic [15:0] digs,
                           input bit r, input bit a, input bit d);
    logic [18:0] got, exp;
    got = {min_tens, min_ones, sec_tens, sec_ones, running, alarm, done};
    exp = {digs, r, a, d};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got digits %h run/alm/done %b, expected digits %h run/alm/done %b",
               name, got[18:3], got[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic idle(input int n);
    rst_n = 1; tick = 0; bmin = 1; bsec = 1; bstart = 1;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst_n = 0; tick = 0; bmin = 1; bsec = 1; bstart = 1;
    cyc();
    rst_n = 1;
  endtask

  // 0 min, 1 sec, 2 start: one-cycle low pulse, then wait until it takes effect
  task automatic press(input int which);
    bmin = (which != 0); bsec = (which != 1); bstart = (which != 2);
    cyc();
    idle(2);
  endtask

  typedef struct {
    bit          rst_n, bmin, bsec, bstart, tick;
    int          reps;
    logic [15:0] digs;
    bit          run, alm, dn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit m, bit s, bit b, bit t, int n,
                              logic [15:0] dg, bit ru, bit al, bit dn);
    vec_t v;
    v.rst_n = r; v.bmin = m; v.bsec = s; v.bstart = b; v.tick = t;
    v.reps = n; v.digs = dg; v.run = ru; v.alm = al; v.dn = dn;
    return v;
  endfunction

  initial begin
    // rst, min, sec, start, tick, reps -> expected digits, running, alarm, done
    tbl.push_back(mk(0,1,1,1,0,1, 16'h0000,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0000,0,0,0));
    tbl.push_back(mk(1,1,0,1,0,1, 16'h0000,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0001,0,0,0));
    tbl.push_back(mk(1,1,0,1,0,1, 16'h0001,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0002,0,0,0));
    tbl.push_back(mk(1,0,1,1,0,1, 16'h0002,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0102,0,0,0));
    tbl.push_back(mk(1,1,1,0,0,1, 16'h0102,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0102,1,0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0101,1,0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0100,1,0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0059,1,0,0));
    tbl.push_back(mk(0,1,1,1,0,1, 16'h0000,0,0,0));
    tbl.push_back(mk(1,1,1,1,1,5, 16'h0000,0,0,0));
    tbl.push_back(mk(1,1,0,1,0,1, 16'h0000,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0001,0,0,0));
    tbl.push_back(mk(1,1,0,1,0,1, 16'h0001,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0002,0,0,0));
    tbl.push_back(mk(1,1,1,0,0,1, 16'h0002,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0002,1,0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0001,1,0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0000,0,1,1));
    tbl.push_back(mk(1,1,1,1,0,1, 16'h0000,0,1,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0000,0,1,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0000,0,1,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0000,0,0,0));
    tbl.push_back(mk(1,1,0,1,0,1, 16'h0000,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0001,0,0,0));
    tbl.push_back(mk(1,1,1,0,0,1, 16'h0001,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,2, 16'h0001,1,0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 16'h0000,0,1,1));
    tbl.push_back(mk(1,1,1,0,0,1, 16'h0000,0,1,0));
    tbl.push_back(mk(1,1,1,1,0,1, 16'h0000,0,1,0));
    tbl.push_back(mk(1,1,1,1,0,1, 16'h0000,0,0,0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; bmin = tbl[i].bmin; bsec = tbl[i].bsec;
      bstart = tbl[i].bstart; tick = tbl[i].tick;
      repeat (tbl[i].reps) cyc();
      check_exp($sformatf("vector %0d", i), tbl[i].digs,
                tbl[i].run, tbl[i].alm, tbl[i].dn);
    end

    // wrap limits and start ignored at 00:00
    do_reset();
    repeat (60) press(1);
    check_exp("sec wrap 59->00", 16'h0000, 0, 0, 0);
    repeat (100) press(0);
    check_exp("min wrap 99->00", 16'h0000, 0, 0, 0);
    press(2);
    idle(2);
    check_exp("start at 00:00 ignored", 16'h0000, 0, 0, 0);
    press(0);
    check_exp("still in set", 16'h0100, 0, 0, 0);

    // tick and start together in RUN, then pause behaviour
    do_reset();
    repeat (5) press(1);
    press(2);
    check_exp("run at 00:05", 16'h0005, 1, 0, 0);
    bstart = 0; cyc();
    bstart = 1; cyc();
    tick = 1; cyc();
    tick = 0;
    check_exp("tick+start -> pause 00:04", 16'h0004, 0, 0, 0);
    tick = 1; repeat (5) cyc();
    tick = 0;
    check_exp("pause holds on ticks", 16'h0004, 0, 0, 0);
    press(0);
    check_exp("min ignored in pause", 16'h0004, 0, 0, 0);
    press(2);
    check_exp("pause resumes run", 16'h0004, 1, 0, 0);
    press(2);
    bstart = 0; bsec = 0; cyc();
    idle(2);
    check_exp("start beats sec in pause", 16'h0004, 1, 0, 0);
    press(2);
    press(1);
    check_exp("sec in pause clears", 16'h0000, 0, 0, 0);
    press(1);
    check_exp("back in set after clear", 16'h0001, 0, 0, 0);

    // held button: one increment, three edges after the fall
    do_reset();
    bmin = 0;
    cyc();
    check_exp("latency edge 1", 16'h0000, 0, 0, 0);
    cyc();
    check_exp("latency edge 2", 16'h0000, 0, 0, 0);
    cyc();
    check_exp("latency edge 3", 16'h0100, 0, 0, 0);
    repeat (997) cyc();
    check_exp("held button no repeat", 16'h0100, 0, 0, 0);
    idle(4);
    check_exp("release no action", 16'h0100, 0, 0, 0);

    // random stimulus against the model
    do_reset();
    for (int k = 0; k < 5000; k++) begin
      rst_n = ($urandom_range(0, 799) != 0);
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) bmin = ~bmin;
      if ($urandom_range(0, 4) == 0) bsec = ~bsec;
      if ($urandom_range(0, 9) == 0) bstart = ~bstart;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kitchen_countdown.md
Name: kitchen_countdown

Overview:
- Countdown controller for the DE0 kitchen timer. It sits directly downstream of the tick generator.
- Consumes the one-cycle tick pulse (1 Hz at 50 MHz with scale=1000) and keeps an MM:SS BCD countdown.
- Handles set/start/pause from three push buttons. Raises an alarm at 00:00.
- Its BCD digit outputs feed the 7-segment decoders.

Parameters:
ALARM_TICKS, 10, number of tick pulses the alarm stays asserted before auto-return to SET (1..255)

Ports:
clk        in   1  system clock, 50 MHz
rst_n      in   1  synchronous active-low reset
tick       in   1  one-cycle pulse from tick generator, synchronous to clk
btn_min_n  in   1  raw minute button, active-low, asynchronous
btn_sec_n  in   1  raw second button, active-low, asynchronous
btn_start_n in  1  raw start/pause button, active-low, asynchronous
min_tens   out  4  BCD minutes tens, 0..9
min_ones   out  4  BCD minutes ones, 0..9
sec_tens   out  4  BCD seconds tens, 0..5
sec_ones   out  4  BCD seconds ones, 0..9
running    out  1  high in RUN
alarm      out  1  high in ALARM
done       out  1  one-cycle pulse on entry to ALARM

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
  - Applies in every state, including mid-RUN and mid-ALARM.
  - Forces: all digits 0, state SET, running=0, alarm=0, done=0, alarm tick counter 0, synchronizer flops to 1 (released).
- Buttons:
  - Each button goes through a 2-flop synchronizer, then falling-edge detection (sync level 1->0).
  - Edge detection gives one press pulse per press; a held button gives no repeat.
  - Action takes effect 3 clk edges after the raw input falls.
  - No debounce in this block; debouncing is upstream or slow enough at button level.
- States: SET, RUN, PAUSE, ALARM. Every output is registered.
- SET:
  - min press: minutes +1 BCD, 99 wraps to 00.
  - sec press: seconds +1 BCD, 59 wraps to 00, no carry into minutes.
  - min and sec pressed in the same cycle: both apply.
  - start press with time != 00:00: go to RUN, no increments that cycle.
  - start press with time == 00:00: ignored, stay in SET, and that cycle's min/sec presses are still applied.
  - tick is ignored.
- RUN:
  - On tick, decrement the time by 1 s, effective the next clk edge:
    - sec_ones 0 -> 9 with borrow into sec_tens.
    - sec_tens 0 -> 5 with borrow into min_ones.
    - min_ones 0 -> 9 with borrow into min_tens.
  - If the decrement produces 00:00: go to ALARM, done=1 for that one cycle, alarm counter cleared.
  - start press: go to PAUSE.
  - tick and start in the same cycle: the decrement is applied first. The result goes to ALARM if 00:00, otherwise to PAUSE.
  - min/sec presses are ignored.
- PAUSE:
  - tick is ignored; time holds.
  - start press: back to RUN.
  - sec press: clear time to 00:00 and go to SET.
  - min press is ignored.
  - start and sec in the same cycle: start wins.
- ALARM:
  - alarm=1 and time holds at 00:00.
  - Each tick increments the alarm counter.
  - On the tick where the counter reaches ALARM_TICKS: go to SET, alarm=0 the next cycle.
  - start press: go to SET immediately and clear the counter.
  - min/sec presses are ignored.
- running = (state==RUN) and alarm = (state==ALARM), both registered with the state.
- BCD digits never hold values above their stated range under any stimulus.

Test Plan:
- Reset mid-RUN at 01:30 (rst_n low for one edge) -> next cycle digits 0/0/0/0, running=0, alarm=0; later ticks leave 00:00.
- From reset: 2 sec presses, 1 min press, start, then 3 ticks -> display 01:02, running=1, then 01:01, 01:00, 00:59 (borrow chain correct, sec_tens 0->5).
- Set 00:60 attempt: 60 sec presses -> 00:00 (wrap at 59); 100 min presses from 00:00 -> 00:00; a start press then is ignored, state stays SET.
- Set 00:02, start, 2 ticks -> done pulses exactly once, alarm=1 one cycle after the second tick.
  - With ALARM_TICKS=3: alarm drops after the 3rd subsequent tick.
  - A repeat run with a start press during the alarm returns to SET immediately.
- RUN at 00:05: tick and start edge in the same cycle -> 00:04 and PAUSE.
  - 5 further ticks -> time stays 00:04.
  - Start -> RUN resumes; sec press in PAUSE -> 00:00 in SET.
- Button held low for 1000 cycles -> exactly one increment.
  - Raw falling edge to digit change = 3 clk edges.
